// File: rtl/uart_wifi_pkg.sv
// Shared constants for the UART Wi-Fi server: bit timing, AT command ROM,
// reply match words and controller state encoding.
`timescale 1ns/1ps
package uart_wifi_pkg;

   localparam int CLK_HZ_NOM  = 50_000_000;
   localparam int BAUD_NOM    = 115_200;
   localparam int BIT_CYC     = CLK_HZ_NOM / BAUD_NOM;
   localparam int HALF_CYC    = BIT_CYC / 2;

   localparam int NUM_CMD     = 7;

   localparam logic [31:0] OK_WORD   = {"OK", 8'h0D, 8'h0A};
   localparam logic [31:0] CONN_WORD = {"CT", 8'h0D, 8'h0A};

   localparam logic [2:0] WAIT_START = 3'd0;
   localparam logic [2:0] SEND       = 3'd1;
   localparam logic [2:0] WAIT_OK    = 3'd2;
   localparam logic [2:0] WAIT_CONN  = 3'd3;
   localparam logic [2:0] SERVE      = 3'd4;

   function automatic logic [4:0] cmdLen(input logic [2:0] idx);
      case (idx)
         3'd0:    return 5'd4;
         3'd1:    return 5'd6;
         3'd2:    return 5'd13;
         3'd3:    return 5'd13;
         3'd4:    return 5'd16;
         3'd5:    return 5'd14;
         3'd6:    return 5'd10;
         default: return 5'd0;
      endcase
   endfunction

   // Strings are right-aligned, so byte 0 of a command sits at the top of its length.
   function automatic logic [7:0] cmdByte(input logic [2:0] idx, input logic [4:0] pos);
      logic [127:0] s;
      logic [4:0]   len;
      logic [4:0]   rev;
      logic [6:0]   sh;
      case (idx)
         3'd0:    s = 128'({"AT", 8'h0D, 8'h0A});
         3'd1:    s = 128'({"ATE0", 8'h0D, 8'h0A});
         3'd2:    s = 128'({"AT+CWMODE=2", 8'h0D, 8'h0A});
         3'd3:    s = 128'({"AT+CIPMUX=1", 8'h0D, 8'h0A});
         3'd4:    s = 128'({"AT+CIPSERVER=1", 8'h0D, 8'h0A});
         3'd5:    s = 128'({"AT+CIPSTO=60", 8'h0D, 8'h0A});
         3'd6:    s = 128'({"AT+CIFSR", 8'h0D, 8'h0A});
         default: s = '0;
      endcase
      len = cmdLen(idx);
      if (pos >= len) return 8'h00;
      rev = len - 5'd1 - pos;
      sh  = {rev[3:0], 3'b000};
      return s[sh +: 8];
   endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit.
`timescale 1ns/1ps
module uart_tx_8n1
   import uart_wifi_pkg::*;
#(
   parameter int CYC_PER_BIT = BIT_CYC
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       txd
);

   localparam int CW = $clog2(CYC_PER_BIT);

   logic [CW-1:0] cycCnt;
   logic [3:0]    bitCnt;
   logic [8:0]    shiftReg;

   // busy covers the whole stop bit, so a new load never shortens it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         txd      <= 1'b1;
         cycCnt   <= '0;
         bitCnt   <= '0;
         shiftReg <= '1;
      end else if (!busy) begin
         if (load) begin
            busy     <= 1'b1;
            txd      <= 1'b0;
            shiftReg <= {1'b1, data};
            cycCnt   <= '0;
            bitCnt   <= '0;
         end
      end else if (cycCnt == CW'(CYC_PER_BIT - 1)) begin
         cycCnt <= '0;
         if (bitCnt == 4'd9) begin
            busy <= 1'b0;
         end else begin
            txd      <= shiftReg[0];
            shiftReg <= {1'b1, shiftReg[8:1]};
            bitCnt   <= bitCnt + 4'd1;
         end
      end else begin
         cycCnt <= cycCnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_wifi_server.sv
// ESP8266-style AT server controller: sends the startup command list, waits for
// OK after each, then shows client data bytes on LED and echoes rx on tx.
`timescale 1ns/1ps
module uart_wifi_server
   import uart_wifi_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int STARTUP_CYC = 5000
) (
   input  logic       iCLK,
   input  logic       RST_n,
   input  logic       tx_en,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] LED,
   output logic       Server_wifi_txd
);

   localparam int BIT_PERIOD  = CLK_HZ / BAUD;
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam int RCW         = $clog2(BIT_PERIOD);
   localparam int SCW         = $clog2(STARTUP_CYC + 1);

   logic [1:0]     rxSync;
   logic           rxPrev;
   logic           rxBusy;
   logic [RCW-1:0] rxCyc;
   logic [3:0]     rxBit;
   logic [7:0]     rxShift;
   logic           rxValid;
   logic [7:0]     rxData;

   logic [31:0]    window;
   logic [2:0]     state;
   logic [2:0]     cmdIdx;
   logic [4:0]     cmdPos;
   logic [SCW-1:0] startCnt;
   logic [4:0]     curLen;
   logic [7:0]     curByte;
   logic           cmdLoad, cmdDone, cmdBusy;
   logic           echoLoad, echoBusy;
   logic           okHit, connHit;

   // Receiver: start bit re-checked at half period, then every bit sampled mid-cell
   always_ff @(posedge iCLK or posedge RST_n) begin
      if (RST_n) begin
         rxSync  <= 2'b11;
         rxPrev  <= 1'b1;
         rxBusy  <= 1'b0;
         rxCyc   <= '0;
         rxBit   <= '0;
         rxShift <= '0;
         rxValid <= 1'b0;
         rxData  <= '0;
      end else begin
         rxSync  <= {rxSync[0], rx};
         rxPrev  <= rxSync[1];
         rxValid <= 1'b0;
         if (!rxBusy) begin
            if (rxPrev && !rxSync[1]) begin
               rxBusy <= 1'b1;
               rxCyc  <= '0;
               rxBit  <= '0;
            end
         end else if (rxBit == 4'd0) begin
            if (rxCyc == RCW'(HALF_PERIOD - 1)) begin
               rxCyc <= '0;
               if (rxSync[1]) rxBusy <= 1'b0;
               else           rxBit  <= 4'd1;
            end else begin
               rxCyc <= rxCyc + RCW'(1);
            end
         end else if (rxCyc == RCW'(BIT_PERIOD - 1)) begin
            rxCyc <= '0;
            if (rxBit == 4'd9) begin
               rxBusy <= 1'b0;
               if (rxSync[1]) begin
                  rxValid <= 1'b1;
                  rxData  <= rxShift;
               end
            end else begin
               rxShift <= {rxSync[1], rxShift[7:1]};
               rxBit   <= rxBit + 4'd1;
            end
         end else begin
            rxCyc <= rxCyc + RCW'(1);
         end
      end
   end

   assign okHit    = (window == OK_WORD);
   assign connHit  = (window == CONN_WORD);
   assign curLen   = cmdLen(cmdIdx);
   assign curByte  = cmdByte(cmdIdx, cmdPos);
   assign cmdLoad  = (state == SEND) && !cmdBusy && (cmdPos < curLen);
   assign cmdDone  = (state == SEND) && !cmdBusy && (cmdPos == curLen);
   assign echoLoad = rxValid && tx_en && !echoBusy;

   // Window is wiped when a command completes so replies seen mid-send never count
   always_ff @(posedge iCLK or posedge RST_n) begin
      if (RST_n) begin
         state    <= WAIT_START;
         cmdIdx   <= '0;
         cmdPos   <= '0;
         startCnt <= '0;
         window   <= '0;
         LED      <= 8'h00;
      end else begin
         if (rxValid) window <= {window[23:0], rxData};
         case (state)
            WAIT_START: begin
               if (startCnt == SCW'(STARTUP_CYC - 1)) state <= SEND;
               else                                   startCnt <= startCnt + SCW'(1);
            end
            SEND: begin
               if (cmdLoad) begin
                  cmdPos <= cmdPos + 5'd1;
               end else if (cmdDone) begin
                  cmdPos <= '0;
                  window <= '0;
                  state  <= WAIT_OK;
               end
            end
            WAIT_OK: begin
               if (okHit) begin
                  cmdIdx <= cmdIdx + 3'd1;
                  state  <= (cmdIdx == 3'(NUM_CMD - 1)) ? WAIT_CONN : SEND;
               end
            end
            WAIT_CONN: begin
               if (connHit) state <= SERVE;
            end
            SERVE: begin
               if (rxValid && rxData != 8'h0D && rxData != 8'h0A) LED <= rxData;
            end
            default: state <= WAIT_START;
         endcase
      end
   end

   uart_tx_8n1 #(.CYC_PER_BIT(BIT_PERIOD)) cmdTx (
      .clock (iCLK),
      .reset (RST_n),
      .load  (cmdLoad),
      .data  (curByte),
      .busy  (cmdBusy),
      .txd   (Server_wifi_txd)
   );

   uart_tx_8n1 #(.CYC_PER_BIT(BIT_PERIOD)) echoTx (
      .clock (iCLK),
      .reset (RST_n),
      .load  (echoLoad),
      .data  (rxData),
      .busy  (echoBusy),
      .txd   (tx)
   );

endmodule

// File: tb/tb_uart_wifi_server.sv
// Scoreboard bench for uart_wifi_server at a scaled line rate of 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_wifi_server;

   localparam int BIT_NS = 320;
   localparam int RX_NS  = 317;

   logic       clock, reset, tx_en, rx, tx, Server_wifi_txd;
   logic [7:0] LED;

   int checkCount = 0;
   int failCount  = 0;
   logic [7:0] swExp[$];
   logic [7:0] echoExp[$];
   bit monEn = 1'b0;

   string cmdText[7] = '{"AT", "ATE0", "AT+CWMODE=2", "AT+CIPMUX=1",
                         "AT+CIPSERVER=1", "AT+CIPSTO=60", "AT+CIFSR"};
   logic [7:0] atBytes[4] = '{8'h41, 8'h54, 8'h0D, 8'h0A};

   uart_wifi_server #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .STARTUP_CYC(50)) dut (
      .iCLK            (clock),
      .RST_n           (reset),
      .tx_en           (tx_en),
      .rx              (rx),
      .tx              (tx),
      .LED             (LED),
      .Server_wifi_txd (Server_wifi_txd)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic lineVal(input int which);
      return (which == 0) ? Server_wifi_txd : tx;
   endfunction

   function automatic int expCount(input int which);
      return (which == 0) ? swExp.size() : echoExp.size();
   endfunction

   // Decodes one 8N1 frame from a DUT output line; got=0 if no frame started in time
   task automatic captureByte(input int which, input int timeoutCyc,
                              output logic [7:0] b, output bit got, output bit stopOk);
      int n = 0;
      b = '0; got = 1'b0; stopOk = 1'b0;
      while (lineVal(which) !== 1'b0 && n < timeoutCyc) begin
         @(negedge clock);
         n++;
      end
      if (lineVal(which) !== 1'b0) return;
      #(BIT_NS / 2 - 10);
      if (lineVal(which) !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         #(BIT_NS);
         b[i] = lineVal(which);
      end
      #(BIT_NS);
      stopOk = (lineVal(which) === 1'b1);
      got    = 1'b1;
   endtask

   task automatic monitorLine(input int which, input string tag);
      logic [7:0] b, e;
      bit got, sok;
      forever begin
         captureByte(which, 1000, b, got, sok);
         if (got && monEn) begin
            if (expCount(which) == 0) begin
               checkOutput({tag, "_unexpected"}, 32'(b), 32'h100);
            end else begin
               e = (which == 0) ? swExp.pop_front() : echoExp.pop_front();
               checkOutput({tag, "_byte"}, 32'(b), 32'(e));
            end
            checkOutput({tag, "_stop"}, 32'(sok), 32'h1);
         end
      end
   endtask

   initial monitorLine(0, "cmd");
   initial monitorLine(1, "echo");

   task automatic applyStimulus(input logic [7:0] d, input bit stopBit);
      rx = 1'b0;
      #(RX_NS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(RX_NS);
      end
      rx = stopBit;
      #(RX_NS);
      if (stopBit && tx_en) echoExp.push_back(d);
      rx = 1'b1;
      #(RX_NS);
   endtask

   task automatic sendLine(input string s);
      for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
      applyStimulus(8'h0D, 1'b1);
      applyStimulus(8'h0A, 1'b1);
   endtask

   task automatic pushCommand(input int k);
      for (int i = 0; i < cmdText[k].len(); i++) swExp.push_back(cmdText[k][i]);
      swExp.push_back(8'h0D);
      swExp.push_back(8'h0A);
   endtask

   task automatic waitDrain(input int which, input int budget, input string tag);
      int n = 0;
      while (expCount(which) != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, 32'(expCount(which)), 32'h0);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: observed time limit reached, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] b;
      bit got, sok, sawLow;
      int n;

      reset = 1'b1; tx_en = 1'b1; rx = 1'b1;
      repeat (50) @(negedge clock);
      checkOutput("reset_tx", 32'(tx), 32'h1);
      checkOutput("reset_swtxd", 32'(Server_wifi_txd), 32'h1);
      checkOutput("reset_led", 32'(LED), 32'h0);

      pushCommand(0);
      monEn = 1'b1;
      reset = 1'b0;

      // Command k is streaming; for k==2 an early OK arrives mid-send and must be ignored
      for (int k = 0; k < 7; k++) begin
         if (k == 2) sendLine("OK");
         waitDrain(0, 4000, "cmd_drain");
         repeat ($urandom_range(300, 100)) @(negedge clock);
         checkOutput("led_before_serve", 32'(LED), 32'h0);
         if (k < 6) pushCommand(k + 1);
         sendLine("OK");
      end
      repeat (2000) @(negedge clock);
      checkOutput("cmd_queue_empty", 32'(swExp.size()), 32'h0);

      sendLine("CONNECT");
      checkOutput("led_after_connect", 32'(LED), 32'h0);
      applyStimulus(8'h33, 1'b1);
      checkOutput("led_data_33", 32'(LED), 32'h33);
      applyStimulus(8'h0D, 1'b1);
      checkOutput("led_hold_cr", 32'(LED), 32'h33);
      applyStimulus(8'h5A, 1'b0);
      checkOutput("led_bad_stop", 32'(LED), 32'h33);
      applyStimulus(8'h0A, 1'b1);
      checkOutput("led_hold_lf", 32'(LED), 32'h33);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("led_data_a5", 32'(LED), 32'hA5);

      fork
         applyStimulus(8'h77, 1'b1);
         begin
            #(2 * RX_NS);
            tx_en = 1'b0;
         end
      join
      sawLow = 1'b0;
      repeat (300) begin
         @(negedge clock);
         if (tx === 1'b0) sawLow = 1'b1;
      end
      checkOutput("tx_idle_en_low", 32'(sawLow), 32'h0);
      tx_en = 1'b1;
      checkOutput("led_data_77", 32'(LED), 32'h77);
      waitDrain(1, 2000, "echo_drain");

      // Restart, then hit reset during the first start bit of "AT"
      monEn = 1'b0;
      reset = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      n = 0;
      while (Server_wifi_txd !== 1'b0 && n < 500) begin
         @(negedge clock);
         n++;
      end
      checkOutput("restart_start_seen", 32'(Server_wifi_txd), 32'h0);
      #100;
      reset = 1'b1;
      #1;
      checkOutput("reset_mid_swtxd", 32'(Server_wifi_txd), 32'h1);
      checkOutput("reset_mid_led", 32'(LED), 32'h0);
      repeat (20) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         captureByte(0, 500, b, got, sok);
         checkOutput("restart_byte_got", 32'(got), 32'h1);
         checkOutput("restart_byte", 32'(b), 32'(atBytes[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
